// File: rtl/fpu_pkg.sv
// fpu_pkg: definitions shared by the single-precision pack and unpack blocks.
//   M_W      : internal mantissa width (hidden bit, 23 fraction bits, guard, round, sticky)
//   E_W      : signed unbiased exponent width
//   EXP_*    : IEEE-754 single-precision exponent bias and normal range
//   fsm_state_t : sequencing states of the pack engine
package fpu_pkg;

  localparam int M_W      = 27;
  localparam int E_W      = 10;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MIN  = -126;
  localparam int EXP_MAX  = 127;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    NORM  = 3'd1,
    ROUND = 3'd2,
    PACK  = 3'd3,
    OUT   = 3'd4
  } fsm_state_t;

endpackage

// File: rtl/fpu_pack_if.sv
// fpu_pack_if: operand-in / result-out handshake bundle of the pack engine.
//   in_valid/in_ready     : operand transfer (in_sign, in_m, in_e)
//   out_valid/out_ready   : result transfer (out_z)
//   master modport : producer of operands and consumer of results
//   slave modport  : the pack engine itself
interface fpu_pack_if #(
  parameter int M_W = fpu_pkg::M_W,
  parameter int E_W = fpu_pkg::E_W
);

  logic           in_valid;
  logic           in_ready;
  logic           in_sign;
  logic [M_W-1:0] in_m;
  logic [E_W-1:0] in_e;
  logic           out_valid;
  logic           out_ready;
  logic [31:0]    out_z;

  modport master (
    output in_valid, in_sign, in_m, in_e, out_ready,
    input  in_ready, out_valid, out_z
  );

  modport slave (
    input  in_valid, in_sign, in_m, in_e, out_ready,
    output in_ready, out_valid, out_z
  );

endinterface

// File: rtl/fpu_round.sv
// fpu_round: combinational round-to-nearest-even on a guard/round/sticky mantissa.
//   m      : mantissa {hidden, fraction, guard, round, sticky}
//   rnd_m  : rounded mantissa with the low three bits cleared; renormalised
//            by one place when the increment carries out of the 24-bit significand
//   carry  : the increment overflowed, so the exponent must go up by one
module fpu_round #(
  parameter int M_W = fpu_pkg::M_W
) (
  input  logic [M_W-1:0] m,
  output logic [M_W-1:0] rnd_m,
  output logic           carry
);

  localparam int F_W = M_W - 3;

  logic           inc_s;
  logic [F_W:0]   sum_s;

  // RNE increment: above half, or exactly half with an odd lsb (m[3]).
  always_comb begin
    inc_s = m[2] & (m[1] | m[0] | m[3]);
    sum_s = {1'b0, m[M_W-1:3]} + {{F_W{1'b0}}, inc_s};
    carry = sum_s[F_W];
    if (sum_s[F_W]) begin
      rnd_m = {sum_s[F_W:1], 3'b000};
    end else begin
      rnd_m = {sum_s[F_W-1:0], 3'b000};
    end
  end

endmodule

// File: rtl/fpu_pack.sv
// fpu_pack: normalises, rounds (RNE) and packs a sign/mantissa/exponent triple
// into an IEEE-754 single-precision word.
//   clk  : sole clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   bus  : fpu_pack_if slave -- operand in (in_*), packed result out (out_*)
// Value of an operand is in_m/2^(M_W-1) * 2^in_e. Normalisation moves one bit
// per cycle, so latency is 3 cycles plus one per shift.
module fpu_pack #(
  parameter int M_W = fpu_pkg::M_W,
  parameter int E_W = fpu_pkg::E_W
) (
  input  logic        clk,
  input  logic        rst,
  fpu_pack_if.slave   bus
);

  import fpu_pkg::*;

  localparam logic signed [E_W-1:0] E_MIN  = E_W'(EXP_MIN);
  localparam logic signed [E_W-1:0] E_MAX  = E_W'(EXP_MAX);
  localparam logic signed [E_W-1:0] E_ONE  = {{(E_W-1){1'b0}}, 1'b1};
  localparam logic        [M_W-1:0] M_ZERO = {M_W{1'b0}};

  fsm_state_t             state_r;
  logic                   sign_r;
  logic [M_W-1:0]         m_r;
  logic signed [E_W-1:0]  e_r;
  logic [31:0]            out_z_r;
  logic                   out_valid_r;
  logic                   in_ready_r;

  logic [M_W-1:0]         rnd_m_s;
  logic                   carry_s;
  logic [7:0]             exp_field_s;
  logic [31:0]            pack_z_s;

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_z     = out_z_r;

  fpu_round #(.M_W(M_W)) u_round (
    .m     (m_r),
    .rnd_m (rnd_m_s),
    .carry (carry_s)
  );

  // Result word from the rounded state; special cases take priority.
  always_comb begin
    // Only used when e is in -126..127, so the 8-bit wrap is exact.
    exp_field_s = e_r[7:0] + 8'(EXP_BIAS);
    if (m_r == M_ZERO) begin
      pack_z_s = {sign_r, 31'h0000_0000};
    end else if (e_r > E_MAX) begin
      pack_z_s = {sign_r, 8'hFF, 23'h00_0000};
    end else if (!m_r[M_W-1]) begin
      pack_z_s = {sign_r, 8'h00, m_r[M_W-2:3]};
    end else begin
      pack_z_s = {sign_r, exp_field_s, m_r[M_W-2:3]};
    end
  end

  // Control FSM and all datapath/output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      sign_r      <= 1'b0;
      m_r         <= M_ZERO;
      e_r         <= {E_W{1'b0}};
      out_z_r     <= 32'h0000_0000;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            sign_r     <= bus.in_sign;
            m_r        <= bus.in_m;
            e_r        <= bus.in_e;
            in_ready_r <= 1'b0;
            state_r    <= NORM;
          end
        end
        NORM: begin
          if (m_r == M_ZERO) begin
            state_r <= ROUND;
          end else if (e_r < E_MIN) begin
            // Denormalise toward EXP_MIN; the lost bit stays in sticky.
            m_r <= {1'b0, m_r[M_W-1:2], m_r[1] | m_r[0]};
            e_r <= e_r + E_ONE;
          end else if (!m_r[M_W-1] && (e_r > E_MIN)) begin
            m_r <= {m_r[M_W-2:0], 1'b0};
            e_r <= e_r - E_ONE;
          end else begin
            state_r <= ROUND;
          end
        end
        ROUND: begin
          m_r <= rnd_m_s;
          if (carry_s) begin
            e_r <= e_r + E_ONE;
          end
          state_r <= PACK;
        end
        PACK: begin
          out_z_r     <= pack_z_s;
          out_valid_r <= 1'b1;
          state_r     <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_pack.sv
// tb_fpu_pack: directed self-checking bench for fpu_pack.
module tb_fpu_pack;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  fpu_pack_if bus();

  fpu_pack dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operand, let it be accepted, and wait for out_valid.
  // Leaves the bench at #1 after the edge where out_valid was first seen.
  task automatic run_op(input logic s, input logic [26:0] m, input logic [9:0] e,
                        output logic [31:0] z, output int lat);
    bus.in_sign  = s;
    bus.in_m     = m;
    bus.in_e     = e;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    z = bus.out_z;
  endtask

  // Complete the pending output transfer.
  task automatic take_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.out_z !== 32'h0000_0000) begin
      errors++; $display("FAIL reset_out_z: got %h want 00000000", bus.out_z);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_normal();
    logic [31:0] z;
    int lat;
    run_op(1'b0, 27'h400_0000, 10'd0, z, lat);
    checks++;
    if (z !== 32'h3F80_0000) begin
      errors++; $display("FAIL one_z: got %h want 3F800000", z);
    end
    checks++;
    if (lat !== 3) begin
      errors++; $display("FAIL one_latency: got %0d want 3", lat);
    end
    take_out();
    // -0.5: exponent -1 -> biased 126
    run_op(1'b1, 27'h400_0000, 10'h3FF, z, lat);
    checks++;
    if (z !== 32'hBF00_0000) begin
      errors++; $display("FAIL neg_half_z: got %h want BF000000", z);
    end
    take_out();
  endtask

  task automatic test_shift();
    logic [31:0] z;
    int lat;
    run_op(1'b0, 27'h000_0008, 10'd23, z, lat);
    checks++;
    if (z !== 32'h3F80_0000) begin
      errors++; $display("FAIL shift23_z: got %h want 3F800000", z);
    end
    checks++;
    if (lat !== 26) begin
      errors++; $display("FAIL shift23_latency: got %0d want 26", lat);
    end
    take_out();
  endtask

  task automatic test_rounding();
    logic [31:0] z;
    int lat;
    // tie with even lsb: stays
    run_op(1'b0, 27'h400_0004, 10'd0, z, lat);
    checks++;
    if (z !== 32'h3F80_0000) begin
      errors++; $display("FAIL rnd_tie_even: got %h want 3F800000", z);
    end
    take_out();
    // tie with odd lsb: rounds up
    run_op(1'b0, 27'h400_000C, 10'd0, z, lat);
    checks++;
    if (z !== 32'h3F80_0002) begin
      errors++; $display("FAIL rnd_tie_odd: got %h want 3F800002", z);
    end
    take_out();
    // all-ones significand carries out -> 2.0
    run_op(1'b0, 27'h7FF_FFFC, 10'd0, z, lat);
    checks++;
    if (z !== 32'h4000_0000) begin
      errors++; $display("FAIL rnd_carry: got %h want 40000000", z);
    end
    take_out();
  endtask

  task automatic test_overflow();
    logic [31:0] z;
    int lat;
    run_op(1'b0, 27'h400_0000, 10'd128, z, lat);
    checks++;
    if (z !== 32'h7F80_0000) begin
      errors++; $display("FAIL pos_inf: got %h want 7F800000", z);
    end
    take_out();
    run_op(1'b1, 27'h400_0000, 10'd128, z, lat);
    checks++;
    if (z !== 32'hFF80_0000) begin
      errors++; $display("FAIL neg_inf: got %h want FF800000", z);
    end
    take_out();
  endtask

  task automatic test_denorm_zero();
    logic [31:0] z;
    int lat;
    // e = -127 (10'h381)
    run_op(1'b0, 27'h400_0000, 10'h381, z, lat);
    checks++;
    if (z !== 32'h0040_0000) begin
      errors++; $display("FAIL denormal_z: got %h want 00400000", z);
    end
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL denormal_latency: got %0d want 4", lat);
    end
    take_out();
    run_op(1'b1, 27'h000_0000, 10'd200, z, lat);
    checks++;
    if (z !== 32'h8000_0000) begin
      errors++; $display("FAIL neg_zero: got %h want 80000000", z);
    end
    take_out();
  endtask

  task automatic test_back_to_back();
    logic [31:0] z;
    int lat;
    run_op(1'b0, 27'h400_0000, 10'd1, z, lat);
    checks++;
    if (z !== 32'h4000_0000) begin
      errors++; $display("FAIL b2b_first_z: got %h want 40000000", z);
    end
    // Next operand offered during the output-transfer edge: must not be taken.
    bus.in_sign  = 1'b0;
    bus.in_m     = 27'h600_0000;
    bus.in_e     = 10'd0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_leave_out: got in_ready=%b out_valid=%b want 1 0",
               bus.in_ready, bus.out_valid);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_accept: got in_ready=%b want 0", bus.in_ready);
    end
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (bus.out_z !== 32'h3FC0_0000 || lat !== 3) begin
      errors++;
      $display("FAIL b2b_second: got z=%h lat=%0d want 3FC00000 3", bus.out_z, lat);
    end
    take_out();
  endtask

  task automatic test_backpressure();
    logic [31:0] z;
    int lat;
    bus.out_ready = 1'b0;
    run_op(1'b0, 27'h500_0000, 10'd2, z, lat);
    checks++;
    if (z !== 32'h40A0_0000) begin
      errors++; $display("FAIL bp_z: got %h want 40A00000", z);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_z !== 32'h40A0_0000 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b z=%h in_ready=%b want 1 40A00000 0",
                 i, bus.out_valid, bus.out_z, bus.in_ready);
      end
    end
    take_out();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got valid=%b in_ready=%b want 0 1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    bus.in_sign  = 1'b0;
    bus.in_m     = 27'h000_0008;
    bus.in_e     = 10'd23;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_z !== 32'h0000_0000) begin
      errors++;
      $display("FAIL midrst_outputs: got valid=%b z=%h want 0 00000000",
               bus.out_valid, bus.out_z);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL midrst_no_output: got out_valid seen=%b want 0", seen);
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_m      = 27'h000_0000;
    bus.in_e      = 10'd0;
    bus.out_ready = 1'b1;
    test_reset();
    test_normal();
    test_shift();
    test_rounding();
    test_overflow();
    test_denorm_zero();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
